// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyphs,
// blank pattern, dp bit position and the scan state encoding.
package seg7_pkg;

  // Segment bus bit that carries the decimal point (active low).
  localparam int SEG_DP_BIT = 0;

  // All segments and dp dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyphs, bit7..bit1 = a..g, bit0 = dp (off).
  // Element 15 is listed first so SEG_HEX[n] is the glyph for nibble n.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h71, 8'h61, 8'h85, 8'h63,   // F E d C
    8'hC1, 8'h11, 8'h09, 8'h01,   // b A 9 8
    8'h1F, 8'h41, 8'h49, 8'h99,   // 7 6 5 4
    8'h0D, 8'h25, 8'h9F, 8'h03    // 3 2 1 0
  };

  typedef enum logic {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Glyph lookup for one hex nibble, dp left off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern with dp
// and a blank override that darkens everything including the dp.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] w_glyph;

  // Glyph lookup, dp cleared when requested, blank wins over both.
  always_comb begin
    w_glyph             = hex_glyph(nib);
    seg                 = w_glyph;
    seg[SEG_DP_BIT]     = w_glyph[SEG_DP_BIT] & ~dp;
    if (blank) seg      = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver. A one-entry pending buffer
// decouples the valid/ready input from the display register, which is
// only updated at frame boundaries so a shown word never tears.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  blank_lz,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dp,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // State
  scan_state_e             r_state;
  scan_state_e             w_state_nxt;
  logic [DIV_W-1:0]        r_div_cnt;
  logic [IDX_W-1:0]        r_dig_idx;

  // Display word and one-entry pending buffer
  logic [4*DIGITS-1:0]     r_disp_data;
  logic [DIGITS-1:0]       r_disp_dp;
  logic [4*DIGITS-1:0]     r_pend_data;
  logic [DIGITS-1:0]       r_pend_dp;
  logic                    r_pend_full;

  // Registered pin drivers
  logic [7:0]              r_seg;
  logic [DIGITS-1:0]       r_an;

  // Datapath wires
  logic                    w_scan_on;
  logic                    w_div_wrap;
  logic                    w_boundary;
  logic                    w_xfer;
  logic [DIGITS-1:0]       w_hi_zero;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blank;
  logic [7:0]              w_seg_dec;
  logic [DIGITS-1:0]       w_one;

  assign w_one      = {{(DIGITS-1){1'b0}}, 1'b1};
  assign in_ready   = ~r_pend_full;
  assign w_xfer     = in_valid & ~r_pend_full;
  // Counters only advance while scanning with enable still high; the
  // first cycle with enable low already behaves as OFF.
  assign w_scan_on  = (r_state == ST_SCAN) && enable;
  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  // Last cycle of the last digit, or any disabled cycle (nothing is lit,
  // so swapping the word cannot tear).
  assign w_boundary = !enable || (w_div_wrap && (r_dig_idx == IDX_LAST));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_OFF;
    else     r_state <= w_state_nxt;
  end

  // Next state: follow enable
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:  if (enable)  w_state_nxt = ST_SCAN;
      ST_SCAN: if (!enable) w_state_nxt = ST_OFF;
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // Dwell counter and digit index; held at 0 whenever not scanning so a
  // restart always begins at digit 0 with a full dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_dig_idx <= '0;
    end else if (!w_scan_on) begin
      r_div_cnt <= '0;
      r_dig_idx <= '0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_dig_idx <= (r_dig_idx == IDX_LAST) ? '0 : r_dig_idx + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Input buffering: pending drains to display at a boundary; with pending
  // empty a word arriving on the boundary itself bypasses straight in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
    end else if (w_boundary) begin
      if (r_pend_full) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
        r_pend_full <= 1'b0;
      end else if (w_xfer) begin
        r_disp_data <= in_data;
        r_disp_dp   <= in_dp;
      end
    end else if (w_xfer) begin
      r_pend_data <= in_data;
      r_pend_dp   <= in_dp;
      r_pend_full <= 1'b1;
    end
  end

  // Per-digit flag: this nibble and every more significant one are zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_hi_zero
    assign w_hi_zero[k] = (r_disp_data[4*DIGITS-1:4*k] == '0);
  end

  // Select the nibble, dp and blank for the digit being scanned.
  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_dig_idx == IDX_W'(k)) begin
        w_nib   = r_disp_data[4*k +: 4];
        w_dp    = r_disp_dp[k];
        w_blank = blank_lz && (k != 0) && w_hi_zero[k];
      end
    end
  end

  hex_to_seg7 u_dec (
    .nib   (w_nib),
    .dp    (w_dp),
    .blank (w_blank),
    .seg   (w_seg_dec)
  );

  // Pin registers: segment and anode change on the same edge, one cycle
  // after dig_idx, so only one anode is ever low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else if (w_scan_on) begin
      r_seg <= w_seg_dec;
      r_an  <= ~(w_one << r_dig_idx);
    end else begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4). Accepted words go
// into a queue; a negedge monitor pops them at each frame start and
// checks every lit digit against a glyph table model.
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_dp = '0;
  logic [7:0]  seg;
  logic [3:0]  an;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .blank_lz (blank_lz),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dp    (in_dp),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference glyphs, index = hex value.
  logic [7:0] HEX_REF [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  function automatic logic [7:0] ref_seg(input logic [15:0] w, input logic [3:0] dp,
                                         input int k, input logic blz);
    logic [3:0] nib;
    nib = w[4*k +: 4];
    if (blz && k > 0 && (w >> (4*k)) == 16'h0) return 8'hFF;
    return HEX_REF[nib] & ~{7'b0, dp[k]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          edge_n;
    logic [15:0] data;
    logic [3:0]  dp;
  } word_t;

  word_t       acc_q[$];
  logic [15:0] cur_w = '0;
  logic [3:0]  cur_dp = '0;
  logic        blz_d = 1'b0;
  logic        en_d = 1'b0;
  logic [3:0]  prev_an = 4'hF;
  int          run = 0;
  int          mk, pk, lim;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      cur_w = '0; cur_dp = '0; prev_an = 4'hF; run = 0;
      en_d = 1'b0; blz_d = blank_lz;
    end else begin
      if (in_valid && in_ready)
        acc_q.push_back('{edge_n: cyc + 1, data: in_data, dp: in_dp});
      if (!en_d) check("dark_after_disable", {an, seg}, {4'hF, 8'hFF});
      if (an == 4'hF) begin
        check("dark_seg", seg, 8'hFF);
        run = 0;
      end else begin
        check("an_onehot", $countones(~an), 1);
        mk = 0;
        for (int i = 3; i >= 0; i--) if (!an[i]) mk = i;
        if (an != prev_an) begin
          if (prev_an == 4'hF) begin
            check("first_digit_after_dark", mk, 0);
          end else begin
            pk = 0;
            for (int i = 3; i >= 0; i--) if (!prev_an[i]) pk = i;
            check("scan_order", mk, (pk + 1) % DIGITS);
            check("dwell", run, SCAN_DIV);
          end
          if (mk == 0) begin
            // A word is in this frame if taken by the edge that started
            // scanning digit 0 after a wrap; after a restart from dark the
            // first scan cycle is not a boundary, so one edge earlier.
            lim = (prev_an == 4'hF) ? cyc - 2 : cyc - 1;
            while (acc_q.size() > 0 && acc_q[0].edge_n <= lim) begin
              cur_w  = acc_q[0].data;
              cur_dp = acc_q[0].dp;
              void'(acc_q.pop_front());
            end
          end
          run = 1;
        end else begin
          run++;
        end
        check($sformatf("seg_digit%0d", mk), seg, ref_seg(cur_w, cur_dp, mk, blz_d));
      end
      prev_an = an;
      en_d    = enable;
      blz_d   = blank_lz;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_an(input logic [3:0] t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (an != t && n < 200);
    check($sformatf("reach_an_%b", t), an, t);
  endtask

  // Call aligned just after a posedge; returns aligned the same way.
  task automatic offer(input logic [15:0] d, input logic [3:0] p, output int stall);
    in_data = d; in_dp = p; in_valid = 1'b1; stall = 0;
    @(negedge clk);
    while (!in_ready && stall < 100) begin
      stall++;
      @(negedge clk);
    end
    check("offer_accepted", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  int st;
  int r;

  initial begin
    // Reset with enable high
    enable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_seg", seg, 8'hFF);
      check("rst_an", an, 4'hF);
      check("rst_ready", in_ready, 1'b1);
    end
    @(posedge clk); #1; rst = 1'b0;
    wait_an(4'b1110); check("first_d0", seg, 8'h03);
    tick(36);

    // Full hex load while off
    enable = 1'b0; tick(2);
    offer(16'hA3F0, 4'b0100, st);
    enable = 1'b1;
    wait_an(4'b1110); check("hex_d0", seg, 8'h03);
    wait_an(4'b1101); check("hex_d1", seg, 8'h71);
    wait_an(4'b1011); check("hex_d2", seg, 8'h0C);
    wait_an(4'b0111); check("hex_d3", seg, 8'h11);
    tick(20);

    // Leading-zero blanking
    enable = 1'b0; blank_lz = 1'b1; tick(2);
    offer(16'h0010, 4'b0000, st);
    enable = 1'b1;
    wait_an(4'b1110); check("lz_d0", seg, 8'h03);
    wait_an(4'b1101); check("lz_d1", seg, 8'h9F);
    wait_an(4'b1011); check("lz_d2", seg, 8'hFF);
    wait_an(4'b0111); check("lz_d3", seg, 8'hFF);
    tick(1);
    offer(16'h0000, 4'b0000, st);
    wait_an(4'b1110); check("lz0_d0", seg, 8'h03);
    wait_an(4'b1101); check("lz0_d1", seg, 8'hFF);
    tick(20);
    blank_lz = 1'b0; tick(20);

    // No tearing: two back-to-back offers mid-frame
    wait_an(4'b1110); wait_an(4'b1101);
    tick(1);
    in_data = 16'h1111; in_dp = 4'b0; in_valid = 1'b1;
    @(negedge clk); check("tear_first_ready", in_ready, 1'b1);
    tick(1); in_valid = 1'b0;
    @(negedge clk); check("tear_ready_drops", in_ready, 1'b0);
    tick(1);
    wait_an(4'b1011); check("tear_old_word", seg, 8'h03);
    tick(1);
    offer(16'h2222, 4'b0000, st);
    check("tear_second_stalled", st > 0, 1'b1);
    wait_an(4'b1110); check("tear_f1_d0", seg, 8'h9F);
    wait_an(4'b0111); check("tear_f1_d3", seg, 8'h9F);
    wait_an(4'b1110); check("tear_f2_d0", seg, 8'h25);
    tick(20);

    // Bypass exactly on the boundary cycle
    wait_an(4'b1110); wait_an(4'b0111);
    tick(2);
    in_data = 16'h0005; in_dp = 4'b0; in_valid = 1'b1;
    @(negedge clk); check("byp_ready", in_ready, 1'b1);
    tick(1); in_valid = 1'b0;
    @(negedge clk); check("byp_ready_stays", in_ready, 1'b1);
    wait_an(4'b1110); check("byp_d0", seg, 8'h49);
    tick(10);

    // Drop enable mid-frame
    wait_an(4'b1011);
    tick(1); enable = 1'b0;
    tick(1); enable = 1'b1;
    @(negedge clk); check("dis_dark", {an, seg}, {4'hF, 8'hFF});
    wait_an(4'b1110); check("dis_restart_seg", seg, 8'h49);

    // Reset with pending full
    wait_an(4'b1101);
    tick(1);
    in_data = 16'h7777; in_valid = 1'b1;
    tick(1); in_valid = 1'b0;
    @(negedge clk); check("pend_full_before_rst", in_ready, 1'b0);
    tick(1); rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_out", {an, seg}, {4'hF, 8'hFF});
    tick(1); rst = 1'b0;
    wait_an(4'b1110); check("midrst_disp0_d0", seg, 8'h03);
    wait_an(4'b0111); check("midrst_disp0_d3", seg, 8'h03);
    tick(1);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        offer(16'($urandom >> $urandom_range(0, 20)), 4'($urandom), st);
        tick($urandom_range(0, 20));
      end else if (r == 6) begin
        blank_lz = ~blank_lz;
        tick($urandom_range(1, 10));
      end else if (r == 7) begin
        enable = 1'b0;
        tick($urandom_range(1, 4));
        if ($urandom_range(0, 1) == 1) offer(16'($urandom), 4'($urandom), st);
        tick($urandom_range(0, 4));
        enable = 1'b1;
        tick(1);
      end else begin
        tick($urandom_range(0, 30));
      end
    end
    tick(40);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

- Drives a bank of `DIGITS` multiplexed seven-segment digits from one shared, active-low segment bus.
- Shows the full hex range 0–F, with a per-digit decimal point and optional leading-zero blanking.
- New values are accepted through a valid/ready handshake and applied only at frame boundaries, so a displayed value never tears.
- Sits between any datapath register (counter, ALU result, encoder output) and the board's segment/anode pins.

## Interface
- `DIGITS`, 8: number of digits scanned; ≥2.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit; ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: 1 = scan, 0 = all digits dark.
- `blank_lz` in 1: 1 = suppress leading zeros.
- `in_valid` in 1: new display word offered.
- `in_ready` out 1: pending buffer empty, word can be taken.
- `in_data` in 4*DIGITS: nibble k is the value for digit k (digit 0 = rightmost).
- `in_dp` in DIGITS: bit k = decimal point on digit k.
- `seg` out 8: active-low segments, bit7..bit1 = a..g, bit0 = dp.
- `an` out DIGITS: active-low digit enables, one-hot-low while scanning.

## Operation
- **Registers:**
  - `disp_data`/`disp_dp` hold the shown word.
  - `pend_data`/`pend_dp`/`pend_full` form a one-entry buffer.
  - `div_cnt` is `$clog2(SCAN_DIV)` bits; `dig_idx` is `$clog2(DIGITS)` bits.
- **Handshake:**
  - `in_ready = !pend_full`.
  - A transfer occurs when `in_valid && in_ready`.
  - `in_data` and `in_dp` must stay stable while `in_valid` is high and `in_ready` is low.
- **Frame boundary:** the cycle where `div_cnt == SCAN_DIV-1` and `dig_idx == DIGITS-1`, or any cycle with `enable == 0`.
- **At a boundary:**
  - If `pend_full`, pending moves to disp and `pend_full` clears.
  - Else, if a transfer occurs in that same cycle, the input word goes directly to disp (bypass) and `pend_full` stays 0.
- **Off a boundary:** a transfer loads pending and sets `pend_full`.
- **State machine:**
  - OFF: `enable == 0`; `an` all 1, `seg = 8'hFF`, counters held at 0. Moves to SCAN when `enable = 1`.
  - SCAN: `div_cnt` increments and wraps at `SCAN_DIV-1`. On wrap, `dig_idx` increments and wraps `DIGITS-1 -> 0`. Returns to OFF on the first cycle with `enable = 0`.
- **Decode (hex, active low, dp bit = 1):** 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71. When `disp_dp[k]` is set, bit0 is cleared.
- **Leading-zero blanking:** with `blank_lz = 1`, digit k ≥ 1 is blanked (`seg = 8'hFF`, dp included) when nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked.

## Timing
- **Reset values:**
  - `seg = 8'hFF`, `an` all 1s, `in_ready = 1`.
  - `disp_*` = 0, `pend_full = 0`, `div_cnt = 0`, `dig_idx = 0`, state OFF.
- **Registered outputs:** `seg` and `an` are registered and change together. The pair for `dig_idx = k` appears one cycle after `dig_idx` becomes k. No cycle ever has two digits enabled.
- **Frame period:** `DIGITS*SCAN_DIV` cycles.
- **Display latency:**
  - Worst case, a word accepted is shown starting one cycle after the next frame boundary.
  - While OFF, the word is in disp the cycle after acceptance.
- **Enable:**
  - Deasserting `enable` darkens outputs on the next edge.
  - Reasserting restarts at digit 0 with `div_cnt = 0`.
- **Reset mid-frame:** returns everything to the reset values immediately; a pending word is discarded.
- **Back-to-back offers:**
  - The second word waits with `in_ready` low until the boundary.
  - At most one word is accepted per frame while SCAN.

## Structure
- **Package `seg7_pkg`:**
  - the 16-entry active-low hex segment constants;
  - `SEG_BLANK = 8'hFF`;
  - the dp bit index.
- **Sub-module `hex_to_seg7`:** combinational. Inputs are a 4-bit nibble, dp and blank; output is 8-bit `seg`. Instantiated once on the muxed digit.

## Test plan
All scenarios use `DIGITS=4`, `SCAN_DIV=4`.
- **Reset and enable:** assert `rst` with `enable = 1`, then release. Expect `seg = FF` and `an = 1111` during reset. The first frame shows digit 0 with `an = 1110`, `seg = 03`. Each anode stays low 4 cycles, in order 1110, 1101, 1011, 0111.
- **Full hex load:** load `in_data = 16'hA3F0`, `in_dp = 4'b0100` while OFF, then enable. Expect digit0 = 03, digit1 = 71, digit2 = 0C (3 with dp), digit3 = 11.
- **Leading-zero blanking:** `blank_lz = 1`, `in_data = 16'h0010`. Expect digits 3 and 2 = FF, digit1 = 9F, digit0 = 03. With `in_data = 0`, only digit0 = 03 is lit.
- **No tearing:** mid-frame offer 16'h1111, then 16'h2222 two cycles later. Expect:
  - the first accepted, `in_ready` drops;
  - the second stalls until the boundary;
  - the frame in progress still shows the old word;
  - the next frame shows all 9F, the one after all 25.
- **Bypass at boundary:** offer 16'h0005 exactly on the boundary cycle with pending empty. Expect `in_ready` to stay 1 and the next digit0 output to be 49.
- **Mid-frame disruption:** drop `enable` mid-frame, expecting FF/1111 next cycle and a restart at `an = 1110`. Pulse `rst` with pending full, expecting `in_ready = 1` and disp = 0.
